// File: rtl/p6502_resp_if.sv
// CPU-side bus bundle for the p6502_resp peripheral: phase, direction,
// address and data from the CPU, read data / chip-select / irq / rdy back.
interface p6502_resp_if;
    logic        phi2;
    logic        rw_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        cs;
    logic        irq;
    logic        rdy;

    modport master (output phi2, rw_n, a, din, input dout, cs, irq, rdy);
    modport slave  (input phi2, rw_n, a, din, output dout, cs, irq, rdy);
endinterface

// File: rtl/p6502_resp.sv
// 6502 bus peripheral: 16-byte register window with scratch registers, a 16-bit
// down timer with irq, and a slow port that inserts wait states through rdy.
module p6502_resp #(
    parameter logic [15:0] BASE = 16'h0800,
    parameter int unsigned WAIT = 2
) (
    input logic         clk,
    input logic         reset_n,
    p6502_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAITING, SERVED} state_t;

    state_t      state;
    logic        phi2_q;
    logic        rise;
    logic        fall;
    logic [15:0] a_s;
    logic        rw_s;
    logic [7:0]  din_s;
    logic [7:0]  scratch0;
    logic [7:0]  scratch1;
    logic [7:0]  latch_lo;
    logic [7:0]  latch_hi;
    logic [7:0]  snap;
    logic [7:0]  slow;
    logic [7:0]  cyc;
    logic [15:0] cnt;
    logic        en;
    logic        cont;
    logic        ie;
    logic        flag;
    logic        underflow;
    logic [3:0]  wait_cnt;
    logic        hit;
    logic        rd_rise;
    logic        wr_fall;
    logic [7:0]  rd_data;
    logic [7:0]  dout_r;
    logic        irq_r;
    logic        rdy_r;

    assign rise      = bus.phi2 & ~phi2_q;
    assign fall      = ~bus.phi2 & phi2_q;
    assign hit       = (bus.a[15:4] == BASE[15:4]);
    assign rd_rise   = rise & bus.rw_n & hit;
    assign wr_fall   = fall & ~rw_s & (a_s[15:4] == BASE[15:4]);
    assign underflow = fall & en & (cnt == 16'h0000);

    assign bus.cs   = hit & bus.phi2;
    assign bus.dout = dout_r;
    assign bus.irq  = irq_r;
    assign bus.rdy  = rdy_r;

    always_comb begin
        rd_data = 8'h00;
        case (bus.a[3:0])
            4'd0:    rd_data = scratch0;
            4'd1:    rd_data = scratch1;
            4'd2:    rd_data = latch_lo;
            4'd3:    rd_data = latch_hi;
            4'd4:    rd_data = cnt[7:0];
            4'd5:    rd_data = snap;
            4'd6:    rd_data = {5'b00000, ie, cont, en};
            4'd7:    rd_data = {7'b0000000, flag};
            4'd8:    rd_data = slow;
            default: rd_data = 8'h00;
        endcase
    end

    // Writes commit on fall from the last address/data seen during the high phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi2_q <= 1'b0;
            a_s    <= 16'h0000;
            rw_s   <= 1'b1;
            din_s  <= 8'h00;
        end else begin
            phi2_q <= bus.phi2;
            if (bus.phi2) begin
                a_s   <= bus.a;
                rw_s  <= bus.rw_n;
                din_s <= bus.din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch0 <= 8'h00;
            scratch1 <= 8'h00;
            latch_lo <= 8'h00;
            latch_hi <= 8'h00;
            snap     <= 8'h00;
            cyc      <= 8'h00;
            cnt      <= 16'h0000;
            en       <= 1'b0;
            cont     <= 1'b0;
            ie       <= 1'b0;
            flag     <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            irq_r <= flag & ie;
            if (rd_rise && bus.a[3:0] == 4'd4) begin
                snap <= cnt[15:8];
            end
            if (fall) begin
                cyc <= cyc + 8'd1;
                if (en) begin
                    if (cnt != 16'h0000) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        flag <= 1'b1;
                        if (cont) begin
                            cnt <= {latch_hi, latch_lo};
                        end else begin
                            en <= 1'b0;
                        end
                    end
                end
                // Later assignments override the timer: a load beats underflow,
                // but the status clear yields to a simultaneous underflow.
                if (wr_fall) begin
                    case (a_s[3:0])
                        4'd0: scratch0 <= din_s;
                        4'd1: scratch1 <= din_s;
                        4'd2: latch_lo <= din_s;
                        4'd3: begin
                            latch_hi <= din_s;
                            cnt      <= {din_s, latch_lo};
                            flag     <= 1'b0;
                        end
                        4'd6: {ie, cont, en} <= din_s[2:0];
                        4'd7: if (din_s[0] && !underflow) flag <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_r <= 8'h00;
        end else if (rise) begin
            dout_r <= (bus.rw_n && hit) ? rd_data : 8'h00;
        end
    end

    // Slow-port wait states: rdy drops after the triggering rise and returns
    // once WAIT falls have elapsed; a repeated read while SERVED is not retriggered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            rdy_r    <= 1'b1;
            slow     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_rise && bus.a[3:0] == 4'd8) begin
                        state    <= WAITING;
                        wait_cnt <= 4'd0;
                        rdy_r    <= 1'b0;
                    end
                end
                WAITING: begin
                    if (fall) begin
                        if (wait_cnt == 4'(WAIT - 1)) begin
                            rdy_r <= 1'b1;
                            slow  <= cyc;
                            state <= SERVED;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                SERVED: begin
                    if (rise && !(rd_rise && bus.a[3:0] == 4'd8)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_p6502_resp.sv
// Self-checking bench for p6502_resp: directed register/timer/wait-state scenarios
// plus randomized bus traffic against a bus-event-level reference model.
module tb_p6502_resp;
    localparam logic [15:0] BASE = 16'h0800;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    p6502_resp_if bus();

    p6502_resp #(.BASE(BASE), .WAIT(WAIT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per clock from the bus phases the bench drives.
    logic [7:0]  m_reg [0:3];
    int          m_cnt;
    bit          m_en, m_cont, m_ie, m_flag;
    logic [7:0]  m_snap, m_slow;
    int          m_cyc;
    int          m_falls_left;
    bit          m_served;
    bit          m_phi2_prev;
    logic [15:0] m_sa;
    bit          m_srw;
    logic [7:0]  m_sdin;
    logic [7:0]  exp_dout;
    bit          exp_irq, exp_rdy, dout_chk;
    bit          seen_cs;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input int off);
        case (off)
            0, 1, 2, 3: return m_reg[off];
            4:          return 8'(m_cnt % 256);
            5:          return m_snap;
            6:          return {5'b00000, m_ie, m_cont, m_en};
            7:          return {7'b0000000, m_flag};
            8:          return m_slow;
            default:    return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_cnt = 0; m_en = 0; m_cont = 0; m_ie = 0; m_flag = 0;
        m_snap = 8'h00; m_slow = 8'h00; m_cyc = 0;
        m_falls_left = 0; m_served = 0; m_phi2_prev = 0;
        m_sa = 16'h0000; m_srw = 1; m_sdin = 8'h00;
        exp_dout = 8'h00; exp_irq = 0; exp_rdy = 1; dout_chk = 1;
    endtask

    task automatic model_rise();
        bit hit, rd;
        int off;
        hit = (bus.a[15:4] == BASE[15:4]);
        off = int'(bus.a[3:0]);
        rd  = bus.rw_n;
        if (hit && rd) begin
            exp_dout = model_read(off);
            dout_chk = 1;
            if (off == 4) m_snap = 8'(m_cnt / 256);
        end else begin
            exp_dout = 8'h00;
            dout_chk = !hit;
        end
        if (m_served) begin
            if (!(hit && rd && off == 8)) m_served = 0;
        end else if (m_falls_left == 0 && hit && rd && off == 8) begin
            m_falls_left = WAIT;
            exp_rdy = 0;
        end
    endtask

    task automatic model_fall();
        bit underflow;
        int off;
        if (m_falls_left > 0) begin
            m_falls_left--;
            if (m_falls_left == 0) begin
                exp_rdy  = 1;
                m_slow   = 8'(m_cyc);
                m_served = 1;
            end
        end
        m_cyc = (m_cyc + 1) % 256;
        underflow = 0;
        if (m_en) begin
            if (m_cnt > 0) begin
                m_cnt--;
            end else begin
                underflow = 1;
                m_flag = 1;
                if (m_cont) m_cnt = int'(m_reg[3]) * 256 + int'(m_reg[2]);
                else m_en = 0;
            end
        end
        off = int'(m_sa[3:0]);
        if (!m_srw && m_sa[15:4] == BASE[15:4]) begin
            case (off)
                0, 1, 2: m_reg[off] = m_sdin;
                3: begin
                    m_reg[3] = m_sdin;
                    m_cnt    = int'(m_sdin) * 256 + int'(m_reg[2]);
                    m_flag   = 0;
                end
                6: {m_ie, m_cont, m_en} = m_sdin[2:0];
                7: if (m_sdin[0] && !underflow) m_flag = 0;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            exp_irq = m_flag && m_ie;
            if (bus.phi2 && !m_phi2_prev) model_rise();
            else if (!bus.phi2 && m_phi2_prev) model_fall();
            if (bus.phi2) begin
                m_sa = bus.a; m_srw = bus.rw_n; m_sdin = bus.din;
            end
            m_phi2_prev = bus.phi2;
        end
    end

    always @(negedge clk) begin
        checkOutput("cs", 16'(bus.cs), 16'(bus.phi2 && (bus.a[15:4] == BASE[15:4])));
        checkOutput("rdy", 16'(bus.rdy), 16'(exp_rdy));
        checkOutput("irq", 16'(bus.irq), 16'(exp_irq));
        if (dout_chk) checkOutput("dout", 16'(bus.dout), 16'(exp_dout));
    end

    // One bus cycle; entered and left 2 time units after a rising clk edge.
    task automatic applyStimulus(input logic [15:0] addr, input bit rw, input logic [7:0] data,
                                 input int hi = 2, input int lo = 3);
        bus.a = addr; bus.rw_n = rw; bus.din = data; bus.phi2 = 1'b1;
        #1 seen_cs = bus.cs;
        repeat (hi) @(posedge clk);
        #2 bus.phi2 = 1'b0;
        repeat (lo) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        applyStimulus(addr, 1'b0, data);
    endtask

    task automatic rdchk(input string name, input logic [15:0] addr, input logic [7:0] expected);
        applyStimulus(addr, 1'b1, 8'h00);
        checkOutput(name, 16'(bus.dout), 16'(expected));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(16'h0000, 1'b1, 8'h00);
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    logic [15:0] ad;
    logic [7:0]  dd;
    int          off;

    initial begin
        bus.phi2 = 1'b0; bus.rw_n = 1'b1; bus.a = 16'h0000; bus.din = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_dout", 16'(bus.dout), 16'h0000);
        checkOutput("reset_rdy", 16'(bus.rdy), 16'h0001);
        checkOutput("reset_irq", 16'(bus.irq), 16'h0000);
        reset_n = 1'b1;
        @(posedge clk);
        #2;

        wr(16'h0800, 8'h5A);
        rdchk("scratch0", 16'h0800, 8'h5A);
        checkOutput("cs_in_window", 16'(seen_cs), 16'h0001);
        rdchk("unused_off12", 16'h080C, 8'h00);
        rdchk("outside_window", 16'h0900, 8'h00);
        checkOutput("cs_outside", 16'(seen_cs), 16'h0000);

        // Continuous timer: reload 3, underflow on the 4th fall after the ctrl write.
        wr(16'h0802, 8'h03);
        wr(16'h0803, 8'h00);
        wr(16'h0806, 8'h07);
        idle(3);
        rdchk("cnt_before_uf", 16'h0804, 8'h00);
        checkOutput("irq_after_uf", 16'(bus.irq), 16'h0001);
        rdchk("cnt_reloaded", 16'h0804, 8'h03);
        rdchk("status_set", 16'h0807, 8'h01);
        wr(16'h0807, 8'h01);
        checkOutput("irq_cleared", 16'(bus.irq), 16'h0000);
        wr(16'h0806, 8'h00);
        wr(16'h0807, 8'h01);

        // One-shot timer.
        wr(16'h0802, 8'h03);
        wr(16'h0803, 8'h00);
        wr(16'h0806, 8'h05);
        idle(4);
        checkOutput("oneshot_irq", 16'(bus.irq), 16'h0001);
        rdchk("oneshot_ctrl", 16'h0806, 8'h04);
        rdchk("oneshot_cnt", 16'h0804, 8'h00);
        wr(16'h0807, 8'h01);
        idle(5);
        rdchk("oneshot_no_reflag", 16'h0807, 8'h00);

        // Snapshot of the high byte.
        wr(16'h0802, 8'h00);
        wr(16'h0803, 8'h01);
        wr(16'h0806, 8'h01);
        rdchk("snap_lo_a", 16'h0804, 8'h00);
        rdchk("snap_hi_a", 16'h0805, 8'h01);
        wr(16'h0803, 8'h01);
        idle(1);
        rdchk("snap_lo_b", 16'h0804, 8'hFF);
        rdchk("snap_hi_b", 16'h0805, 8'h00);
        wr(16'h0806, 8'h00);

        // Slow port; after reset the first fall sees cyc=0, the second cyc=1.
        pulseReset();
        applyStimulus(16'h0808, 1'b1, 8'h00);
        checkOutput("slow_rdy_low", 16'(bus.rdy), 16'h0000);
        applyStimulus(16'h0808, 1'b1, 8'h00);
        checkOutput("slow_rdy_back", 16'(bus.rdy), 16'h0001);
        rdchk("slow_captured", 16'h0808, 8'h01);
        checkOutput("slow_no_retrigger", 16'(bus.rdy), 16'h0001);
        rdchk("slow_exit", 16'h0800, 8'h00);
        wr(16'h0802, 8'h00);
        wr(16'h0803, 8'h00);
        wr(16'h0806, 8'h05);
        idle(1);
        checkOutput("pre_reset_irq", 16'(bus.irq), 16'h0001);

        // Reset in the middle of a wait state.
        bus.a = 16'h0808; bus.rw_n = 1'b1; bus.phi2 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("mid_wait_rdy", 16'(bus.rdy), 16'h0000);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rdy", 16'(bus.rdy), 16'h0001);
        checkOutput("async_irq", 16'(bus.irq), 16'h0000);
        checkOutput("async_dout", 16'(bus.dout), 16'h0000);
        bus.phi2 = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) rdchk("post_reset_reg", BASE + 16'(i), 8'h00);

        // Randomized traffic; small timer values keep underflows frequent.
        for (int i = 0; i < 400; i++) begin
            off = $urandom_range(0, 11);
            if ($urandom_range(0, 9) == 0) ad = 16'($urandom);
            else ad = BASE + 16'(off > 9 ? $urandom_range(0, 15) : off);
            dd = 8'($urandom);
            if (ad[3:0] == 4'd3) dd = 8'h00;
            if (ad[3:0] == 4'd2) dd = 8'($urandom_range(0, 5));
            applyStimulus(ad, 1'($urandom_range(0, 1)), dd, $urandom_range(1, 3), $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
